// File: rtl/preset_loader_if.sv
// Board-memory write port between the preset loader and the life board memory.
// A write is taken on any cycle where mem_we and mem_ready are both high.
interface preset_loader_if #(
    parameter int AW = 2,
    parameter int DW = 16
) ();
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_ready;

    modport master (output mem_we, output mem_addr, output mem_data, input mem_ready);
    modport slave  (input mem_we, input mem_addr, input mem_data, output mem_ready);
endinterface

// File: rtl/preset_loader.sv
// Seeds the life board: on a debounced button press, writes one preset pattern
// into board words 0..NUM_WORDS-1 and flags busy so the generation controller holds off.
module preset_loader #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NUM_WORDS       = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_btn,
    input  logic [3:0]              selector,
    preset_loader_if.master         mem,
    output logic                    busy,
    output logic                    done
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int AW = 2;

    typedef enum logic [2:0] {
        S_IDLE, S_DEBOUNCE, S_LOAD, S_DONE, S_RELEASE
    } state_t;

    state_t          state, state_n;
    logic [1:0]      sync_q;
    logic            btn_s;
    logic [CW-1:0]   deb_cnt;
    logic [WW-1:0]   wcnt, wcnt_n;
    logic [3:0]      sel_q, sel_n;
    logic            accept, last_word;

    logic            we_d, busy_d, done_d;
    logic [AW-1:0]   addr_d;
    logic [15:0]     data_d;

    function automatic logic [15:0] rom(input logic [3:0] sel, input logic [WW-1:0] w);
        logic first;
        first = (w == '0);
        case (sel)
            4'd1:    rom = first ? 16'h0070 : 16'h0000;
            4'd2:    rom = first ? 16'h0660 : 16'h0000;
            4'd3:    rom = first ? 16'h0742 : 16'h0000;
            4'd4:    rom = 16'hFFFF;
            4'd5:    rom = 16'hA5A5;
            default: rom = 16'h0000;
        endcase
    endfunction

    // load_btn is asynchronous to clk; only btn_s is used downstream
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[0], load_btn};
    end
    assign btn_s = sync_q[1];

    assign accept    = mem.mem_we & mem.mem_ready;
    assign last_word = (wcnt == WW'(NUM_WORDS - 1));

    // State register; outputs are registered alongside so they reset to 0 asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            mem.mem_we   <= 1'b0;
            mem.mem_addr <= '0;
            mem.mem_data <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            mem.mem_we   <= we_d;
            mem.mem_addr <= addr_d;
            mem.mem_data <= data_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:     if (btn_s) state_n = S_DEBOUNCE;
            S_DEBOUNCE: begin
                if (!btn_s)                                  state_n = S_IDLE;
                else if (deb_cnt == CW'(DEBOUNCE_CYCLES - 1)) state_n = S_LOAD;
            end
            S_LOAD:     if (accept && last_word) state_n = S_DONE;
            S_DONE:     state_n = S_RELEASE;
            S_RELEASE:  if (!btn_s) state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    // Next word index and selector feed the output decode so the registered
    // outputs line up with the state they belong to.
    always_comb begin
        wcnt_n = wcnt;
        sel_n  = sel_q;
        if (state == S_DEBOUNCE && state_n == S_LOAD) begin
            wcnt_n = '0;
            sel_n  = selector;
        end else if (state == S_LOAD && accept) begin
            wcnt_n = wcnt + WW'(1);
        end
    end

    always_comb begin
        we_d   = (state_n == S_LOAD);
        addr_d = we_d ? AW'(wcnt_n) : '0;
        data_d = we_d ? rom(sel_n, wcnt_n) : 16'h0000;
        busy_d = (state_n == S_LOAD) || (state_n == S_DONE);
        done_d = (state_n == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_cnt <= '0;
            wcnt    <= '0;
            sel_q   <= '0;
        end else begin
            wcnt  <= wcnt_n;
            sel_q <= sel_n;
            if (state == S_IDLE)
                deb_cnt <= '0;
            else if (state == S_DEBOUNCE && btn_s)
                deb_cnt <= deb_cnt + CW'(1);
        end
    end
endmodule

// File: doc/preset_loader.md
Name: preset_loader

Overview:
- Upstream seeding stage for the life board memory.
- On a debounced load-button press, writes one of several preset 16-bit cell patterns into the four board words, array positions 0..3, over the memory write port.
- Asserts busy while loading so the generation controller holds off run and write-back; pulses done on completion.
- Each 16-bit word is one 4x4 tile; bit index = row*4 + col, row 0 is the top.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive cycles the synchronised button must stay high before a load starts (10 ms at 100 MHz). Legal range >= 2.
- NUM_WORDS, 4: number of board words written per load; addresses 0..NUM_WORDS-1.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  reset, asynchronous, active-low.
- load_btn  input  1  raw, asynchronous push-button request.
- selector  input  4  preset index; sampled once at load start.
- mem_ready  input  1  memory can accept a write this cycle.
- mem_we  output  1  write strobe for the board memory.
- mem_addr  output  2  board word address (array position).
- mem_data  output  16  pattern word being written.
- busy  output  1  load in progress; controller must suspend run and write-back.
- done  output  1  single-cycle pulse after the last word is accepted.

Behaviour:
- Reset (reset=0, asynchronous): FSM to IDLE; synchroniser flops, debounce counter, word counter and latched selector cleared.
- Output reset values: mem_we=0, mem_addr=0, mem_data=0, busy=0, done=0. Reset mid-load aborts immediately; words already written are not rolled back.
- load_btn passes through a 2-flop synchroniser (btn_s) before any use.
- IDLE:
  - btn_s=1 -> DEBOUNCE, counter cleared.
- DEBOUNCE:
  - Counter increments each cycle btn_s=1.
  - btn_s=0 at any point -> IDLE.
  - Counter reaches DEBOUNCE_CYCLES-1 with btn_s=1 -> LOAD; selector latched to sel_q; word counter=0; busy rises on LOAD entry.
- LOAD:
  - Outputs are registered: mem_we=1, mem_addr=word counter, mem_data=ROM(sel_q, word counter).
  - A write is accepted on a cycle with mem_we=1 and mem_ready=1; the word counter then advances.
  - mem_ready=0: hold addr, data and we stable (stall), no advance.
  - Accepted write of word NUM_WORDS-1 -> DONE; mem_we=0 on the next cycle.
- DONE:
  - One cycle: done=1, busy=1.
  - Then -> RELEASE.
- RELEASE:
  - busy=0; waits for btn_s=0, then -> IDLE.
  - A held button therefore triggers exactly one load.
- selector changes after the latch have no effect on the load in progress.
- busy=1 exactly in LOAD and DONE. Latency from the first debounced-high cycle to the first mem_we: DEBOUNCE_CYCLES+1 cycles. Minimum LOAD duration: NUM_WORDS cycles.
- Preset ROM (combinational on sel_q and word index):
  - sel 0: all words 16'h0000 (clear).
  - sel 1: blinker, word0=16'h0070, others 0.
  - sel 2: block, word0=16'h0660, others 0.
  - sel 3: glider, word0=16'h0742, others 0.
  - sel 4: all words 16'hFFFF.
  - sel 5: checkerboard, all words 16'hA5A5.
  - sel 6..15: all words 16'h0000.
- mem_data=0 whenever mem_we=0.

Test Plan:
- Reset, then button held past debounce with selector=3 -> after DEBOUNCE_CYCLES+1 cycles, mem_we high 4 cycles with addr 0,1,2,3 and data 0742,0000,0000,0000; done pulses once; busy high 5 cycles.
- Button glitch high for DEBOUNCE_CYCLES-2 cycles, then low -> no mem_we, no busy, FSM back in IDLE.
- selector=5, mem_ready held low for 3 cycles during word 1 -> addr=1 and data=A5A5 held stable; exactly 4 accepted writes; done follows the word 3 acceptance.
- Button held 3x DEBOUNCE_CYCLES -> exactly one load; release, then press again with selector=4 -> second load writes FFFF x4.
- selector switched from 1 to 2 mid-LOAD -> all words still come from preset 1 (word0=0070).
- reset asserted during word 2 -> all outputs 0 asynchronously; after release, FSM in IDLE; no done pulse.
